// File: rtl/regfile_pkg.sv
// Shared constants and types for the RV32 integer register file and its write scoreboard.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int ZERO_REG      = 0;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xdata_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, set wins on same-address collision.
// Outputs are registered (visible the cycle after the edge); accepts iss/wb every cycle, no backpressure.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEFAULT,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      r_cnt;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;

    assign w_set = iss_valid && (iss_addr != AW'(ZERO_REG));
    // A writeback to the register being re-issued this cycle must not clear it.
    assign w_clr = wb_valid && (wb_addr != AW'(ZERO_REG)) && !(w_set && (wb_addr == iss_addr));

    // Count only real bit transitions so WAW issues and stray writebacks leave the count alone.
    assign w_inc = w_set && !r_busy[iss_addr];
    assign w_dec = w_clr && r_busy[wb_addr];

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file (x0 = 0) with write scoreboard; reads combinational, writes at the edge.
// No backpressure. Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   wb_valid,
    input  logic [AW-1:0]          wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    output logic [AW:0]            busy_cnt,
    output logic                   all_idle
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;
    logic [AW:0]      w_busy_cnt;
    logic             w_we;

    assign w_we = wb_valid && (wb_addr != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    rf_scoreboard #(
        .NREGS     (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .busy      (w_busy),
        .busy_cnt  (w_busy_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_bsy;

        assign w_addr = rd_addr[k*AW +: AW];

        always_comb begin
            w_data = (w_addr == AW'(ZERO_REG)) ? '0 : r_regs[w_addr];
            w_bsy  = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarded value is complete unless a new producer claims the register this cycle.
            if (w_we && (wb_addr == w_addr)) begin
                w_data = wb_data;
                w_bsy  = iss_valid && (iss_addr == w_addr);
            end
`endif
        end

        assign rd_data[k*XLEN +: XLEN] = w_data;
        assign rd_busy[k]              = w_bsy;
    end

    assign busy_cnt = w_busy_cnt;
    assign all_idle = (w_busy_cnt == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed stimulus for regfile_sb (3 read ports) against an array-based reference model.
module tb_regfile_sb;

    localparam int NR = 3;

    logic          clk;
    logic          rst;
    logic [14:0]   rd_addr;
    logic [95:0]   rd_data;
    logic [2:0]    rd_busy;
    logic          iss_valid;
    logic [4:0]    iss_addr;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [5:0]    busy_cnt;
    logic          all_idle;

    regfile_sb #(
        .XLEN      (32),
        .NREGS     (32),
        .NUM_RD    (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy_cnt  (busy_cnt),
        .all_idle  (all_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] d;
        logic [2:0]  b;
        logic [5:0]  cnt;
        logic        idle;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    // Drive one cycle, queue the expected outputs for this cycle, then advance the model past the edge.
    task automatic step(input bit r, input bit iv, input logic [4:0] ia, input bit wv,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        exp_t        e;
        logic [4:0]  a [3];
        logic [31:0] d;
        bit          b;
        int          pop;
        rst = r; iss_valid = iv; iss_addr = ia; wb_valid = wv; wb_addr = wa; wb_data = wd;
        rd_addr = {a2, a1, a0};
        a[0] = a0; a[1] = a1; a[2] = a2;
        e = '0;
        for (int k = 0; k < NR; k++) begin
            d = (a[k] == 0) ? 32'h0 : m_regs[a[k]];
            b = m_busy[a[k]];
`ifdef REGFILE_BYPASS_EN
            if (wv && wa != 0 && wa == a[k]) begin
                d = wd;
                b = iv && (ia == a[k]);
            end
`endif
            e.d[k*32 +: 32] = d;
            e.b[k]          = b;
        end
        pop = 0;
        for (int i = 0; i < 32; i++) pop += int'(m_busy[i]);
        e.cnt  = 6'(pop);
        e.idle = (pop == 0);
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (wv && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 0;
            end
            if (iv && ia != 0) m_busy[ia] = 1;
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        step(0, 0, 5'd0, 0, 5'd0, 32'h0, a0, a1, a2);
    endtask

    // Monitor: outputs are present every cycle; compare mid-cycle against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < NR; k++) begin
                    check($sformatf("rd_data[%0d]", k), rd_data[k*32 +: 32], e.d[k*32 +: 32]);
                    check($sformatf("rd_busy[%0d]", k), {31'h0, rd_busy[k]}, {31'h0, e.b[k]});
                end
                check("busy_cnt", {26'h0, busy_cnt}, {26'h0, e.cnt});
                check("all_idle", {31'h0, all_idle}, {31'h0, e.idle});
            end
        end
    end

    initial begin : driver
        rst = 1'b1; iss_valid = 1'b0; iss_addr = '0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset clears state written beforehand
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 5'($urandom_range(1, 31)), 1, 5'($urandom_range(1, 31)), $urandom,
                 5'($urandom), 5'($urandom), 5'($urandom));
        end
        step(1, 0, 5'd0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3);
        idle_read(5'd1, 5'd2, 5'd3);
        idle_read(5'd4, 5'd5, 5'd31);

        // x0 is never written nor busy
        step(0, 1, 5'd0, 1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0, 5'd0);

        // Issue then writeback x5
        step(0, 1, 5'd5, 0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
        idle_read(5'd5, 5'd5, 5'd5);
        step(0, 0, 5'd0, 1, 5'd5, 32'h12345678, 5'd5, 5'd5, 5'd5);
        idle_read(5'd5, 5'd5, 5'd5);

        // Same-address issue/writeback collision on x7
        step(0, 1, 5'd7, 0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        step(0, 1, 5'd7, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7, 5'd7);
        step(0, 0, 5'd0, 1, 5'd7, 32'h0000_0007, 5'd7, 5'd0, 5'd0);

        // Multi-port read ordering
        step(0, 0, 5'd0, 1, 5'd1, 32'd1, 5'd0, 5'd0, 5'd0);
        step(0, 0, 5'd0, 1, 5'd2, 32'd2, 5'd0, 5'd0, 5'd0);
        step(0, 0, 5'd0, 1, 5'd3, 32'd3, 5'd0, 5'd0, 5'd0);
        idle_read(5'd3, 5'd2, 5'd1);

        // Write/read same cycle on x9
        step(0, 0, 5'd0, 1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9, 5'd9);
        idle_read(5'd9, 5'd9, 5'd9);

        // WAW issue and writeback to an idle register
        step(0, 1, 5'd12, 0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd0);
        step(0, 1, 5'd12, 1, 5'd13, 32'h1313_1313, 5'd12, 5'd13, 5'd0);
        idle_read(5'd12, 5'd13, 5'd0);

        // Random traffic, addresses biased low to provoke collisions
        for (int i = 0; i < 500; i++) begin
            logic [4:0] ia;
            logic [4:0] wa;
            ia = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            step(($urandom_range(0, 59) == 0), 1'($urandom), ia, 1'($urandom), wa, $urandom,
                 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom));
        end

        // Fill every register busy to reach the top of the count range
        for (int i = 1; i < 32; i++) begin
            step(0, 1, 5'(i), 0, 5'd0, 32'h0, 5'(i), 5'd0, 5'd31);
        end
        idle_read(5'd31, 5'd1, 5'd0);

        @(negedge clk);
        #1;
        check("queue_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port integer register file with an integrated write scoreboard, for the RV32 decode/writeback stages.
- x0 is hardwired to zero.
- Per-register busy bits are set when a destination is issued and cleared on writeback, so decode can detect RAW hazards without extra logic.
- Successor to the single-config 2R1W file: adds width/depth/port generality, x0 handling, a scoreboard and optional write-to-read bypass.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, at least 2).
- NUM_RD, 2, number of combinational read ports (1..4).
- AW, $clog2(NREGS), register address width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port busy flag for the addressed register.
- iss_valid  in  1  instruction issued with a destination register.
- iss_addr  in  AW  destination register being issued.
- wb_valid  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- busy_cnt  out  AW+1  number of registers currently marked busy.
- all_idle  out  1  high when busy_cnt == 0.

Behaviour:
- Reset
  - rst sampled at posedge clk.
  - All NREGS registers, all busy bits and busy_cnt are cleared; all_idle = 1 from the next cycle.
  - rst has priority over iss/wb in the same cycle; an outstanding operation is simply discarded.
- Write
  - On posedge with wb_valid=1 and wb_addr != 0: regs[wb_addr] <= wb_data.
  - Writes to address 0 are dropped.
- Read
  - rd_data[k] = 0 if rd_addr[k] == 0, else regs[rd_addr[k]].
  - Purely combinational; new data is visible the cycle after the write edge (no bypass unless the optional feature is enabled).
- Scoreboard, evaluated per posedge:
  - iss_valid with iss_addr != 0 sets busy[iss_addr].
  - wb_valid with wb_addr != 0 clears busy[wb_addr].
  - Same address, both asserted in the same cycle: set wins. The new producer is outstanding, and the data write still happens.
  - Different addresses: both take effect.
  - Issue to an already-busy register: busy stays 1 and busy_cnt is unchanged (WAW allowed; single bit, not a counter).
  - Writeback to a non-busy register: data is written, busy stays 0, and busy_cnt does not underflow.
  - Address 0 is never busy.
- rd_busy[k] = busy[rd_addr[k]], combinational.
- busy_cnt
  - Registered population count of the busy bits, updated incrementally: +1, −1 or 0 per cycle according to the actual bit transitions above.
  - Range 0..NREGS−1.
- all_idle = (busy_cnt == 0), combinational from the register.
- No backpressure: iss and wb are accepted every cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If wb_valid=1, wb_addr != 0 and wb_addr == rd_addr[k], then rd_data[k] = wb_data in the same cycle.
  - rd_busy[k] is forced to 0 for that port unless iss_valid targets the same address in that cycle.
- Undefined: reads return the stored value; writeback data is visible one cycle later, and rd_busy reflects the registered bit only.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEFAULT = 32 and NREGS_DEFAULT = 32.
  - Typedef reg_addr_t (logic [4:0]).
  - Typedef xdata_t (logic [31:0]).
  - Constant ZERO_REG = 0.
- One sub-module, rf_scoreboard, holds the busy bit vector and busy_cnt with their set/clear priority logic.
- The data array and read muxing stay in the top level.

Test Plan:
- Reset: pulse rst for 1 cycle after random writes -> every rd_data = 0, busy_cnt = 0, all_idle = 1.
- x0: wb_valid with wb_addr=0, wb_data=32'hDEADBEEF; iss_addr=0 -> rd_data for addr 0 = 0, rd_busy = 0, busy_cnt = 0.
- Scoreboard:
  - Issue x5 -> next cycle rd_busy(x5)=1, busy_cnt=1.
  - Then wb x5 = 32'h12345678 -> next cycle rd_data(x5)=32'h12345678, rd_busy=0, busy_cnt=0.
- Collision: busy[x7]=1, same cycle iss_addr=7 and wb_addr=7 with 32'hA5A5A5A5 -> x7 holds 32'hA5A5A5A5, busy stays 1, busy_cnt unchanged.
- Multi-port, NUM_RD=3: write x1=1, x2=2, x3=3; read (3,2,1) -> rd_data = {1,2,3} packed per port order.
- Bypass: wb x9 = 32'hCAFEF00D while reading x9.
  - With REGFILE_BYPASS_EN: same-cycle rd_data = 32'hCAFEF00D.
  - Without REGFILE_BYPASS_EN: same cycle returns the old value, and the next cycle returns 32'hCAFEF00D.
